viterbi_acs_array: RTL and testbench
====================================

// Module: viterbi_acs_array
// PURPOSE
// - Parametrised add-compare-select array for a rate-1/2, constraint-length-K Viterbi decoder: all 2^(K-1) states are updated per symbol.
// - Sits between the branch-metric unit (hard or soft) and the traceback/survivor memory; emits one decision vector per symbol.
// - Adds what the single-state (2,1,3) ACS lacks: generic K/G0/G1/widths, saturating arithmetic, metric renormalisation, best-state search, frame start, valid/ready flow control.
// PARAMETERS
// - K    3       constraint length; N_ST = 2^(K-1) states (localparam)
// - G0   3'o7    generator polynomial, first code bit c0 (K bits, bit K-1 = newest input)
// - G1   3'o5    generator polynomial, second code bit c1
// - W    4       path-metric width; MAX = 2^W-1
// - BMW  2       branch-metric width per hypothesis
// PORTS
// - clock        in   1          rising-edge clock
// - reset        in   1          asynchronous, active-high
// - start        in   1          qualified by bm_valid: this symbol begins a new frame
// - bm_valid     in   1          branch metrics valid
// - bm_ready     out  1          array can accept a symbol
// - bm           in   4*BMW      bm[{c0,c1}*BMW +: BMW] = cost of hypothesis {c0,c1}
// - dec_valid    out  1          decision vector valid
// - dec_ready    in   1          downstream accepts decision vector
// - dec          out  N_ST       dec[j] = survivor select of state j (0 = upper, 1 = lower)
// - best_state   out  K-1        index of minimum stored metric
// - best_metric  out  W          value of minimum stored metric
// - norm_pulse   out  1          set with dec_valid when this update renormalised
// BEHAVIOUR
// - Trellis: next state j = {u, s[K-2:1]}, u = j[K-2]; predecessors p0 = (j<<1)&(N_ST-1), p1 = p0|1.
// - Expected bits for predecessor p: r = {u,p}; c0 = ^(r & G0), c1 = ^(r & G1).
// - Add: cand = pm[p] + bm[{c0,c1}], saturating at MAX; pm[p]==MAX gives MAX (unreachable stays unreachable).
// - Compare/select: cand0 <= cand1 -> new = cand0, dec[j] = 0; else new = cand1, dec[j] = 1 (ties pick upper).
// - Renormalise: if every new[j] >= 2^(W-1), store new[j] - 2^(W-1) for all j (MAX included) and set norm_pulse.
// - start: predecessor metrics for that symbol are the init vector {pm[0]=0, pm[j!=0]=MAX}, not stored pm.
// - Handshake: transfer when bm_valid && bm_ready; bm_ready = !dec_valid || dec_ready.
// - Latency 1: symbol accepted at edge t -> pm, dec, norm_pulse, best_* updated and dec_valid=1 after edge t.
// - Output holds stable while dec_valid && !dec_ready; dec_valid drops after a handshake with no new transfer.
// - Simultaneous dec handshake and new bm transfer in one cycle: new result replaces old, dec_valid stays 1 (full throughput).
// - best_state/best_metric: registered, computed from new stored metrics; tie -> lowest index.
// - Reset (any time, including mid-frame): pm = init vector, dec_valid=0, dec=0, norm_pulse=0, best_state=0, best_metric=0.
// - bm values are unconstrained; width of sums is W+1 internally before saturation.
// STRUCTURE
// - Shared package viterbi_pkg: K, N_ST, G0, G1, W, BMW defaults, MAX, init-vector function, expected-bits function.
// - One sub-module: viterbi_acs_butterfly (two cands for p0/p1 -> two next states 2i>>... with saturating add, select, dec bits); array instantiates N_ST/2 copies.
// - Top holds pm register file, renorm detect, min-search tree, handshake register.
// TESTING (K=3, G 7/5, W=4, BMW=2, hard decisions: bm = {00:0,01:1,10:1,11:2} for rx 00)
// - Reset, idle -> dec_valid=0, pm={0,F,F,F}, bm_ready=1, best_state=0, best_metric=0.
// - start + rx 00, dec_ready=1 -> next cycle pm={0,F,2,F}, dec=4'b0000, best_state=0, best_metric=0, norm_pulse=0.
// - start, then bm all =1 for 8 symbols -> after symbol n>=2 all pm=n; symbol 8 stores pm={0,0,0,0}, norm_pulse=1.
// - dec_ready=0 for 3 cycles with bm_valid=1 -> bm_ready=0, dec/pm/best_* frozen; dec_ready=1 -> one transfer per cycle resumes, no symbol lost or duplicated.
// - Tie: pm[0]=pm[1]=3 and equal cands into state 0 -> dec[0]=0; equal minima in states 1 and 3 -> best_state=1.
// - Assert reset mid-frame after 5 symbols -> pm={0,F,F,F}, dec_valid=0 same cycle; next start-symbol result matches scenario 2.

Source files
------------

// File: rtl/viterbi_pkg.sv
// rtl/viterbi_pkg.sv - shared defaults and trellis helpers for the Viterbi ACS array
package viterbi_pkg;
  localparam int K_DEF    = 3;
  localparam int G0_DEF   = 'o7;
  localparam int G1_DEF   = 'o5;
  localparam int W_DEF    = 4;
  localparam int BMW_DEF  = 2;
  localparam int N_ST_DEF = 1 << (K_DEF - 1);
  localparam int MAX_DEF  = (1 << W_DEF) - 1;

  // Frame-start metric: only state 0 is reachable, the rest sit at MAX.
  function automatic int unsigned init_metric(input int unsigned st, input int unsigned w);
    return (st == 0) ? 0 : (1 << w) - 1;
  endfunction

  // r = {u, predecessor}; returns {c0, c1}, which is also the branch-metric hypothesis index.
  function automatic logic [1:0] expected_bits(input int unsigned r, input int unsigned g0,
                                               input int unsigned g1);
    return {^(r & g0), ^(r & g1)};
  endfunction
endpackage

// File: rtl/viterbi_acs_array_if.sv
// rtl/viterbi_acs_array_if.sv - branch-metric input and decision output channels of the ACS array
interface viterbi_acs_array_if
  import viterbi_pkg::*;
#(
  parameter int K   = K_DEF,
  parameter int W   = W_DEF,
  parameter int BMW = BMW_DEF
);
  localparam int N_ST = 1 << (K - 1);

  logic               start;
  logic               bm_valid;
  logic               bm_ready;
  logic [4*BMW-1:0]   bm;
  logic               dec_valid;
  logic               dec_ready;
  logic [N_ST-1:0]    dec;
  logic [K-2:0]       best_state;
  logic [W-1:0]       best_metric;
  logic               norm_pulse;

  modport master (
    output start, bm_valid, bm, dec_ready,
    input  bm_ready, dec_valid, dec, best_state, best_metric, norm_pulse
  );

  modport slave (
    input  start, bm_valid, bm, dec_ready,
    output bm_ready, dec_valid, dec, best_state, best_metric, norm_pulse
  );
endinterface

// File: rtl/viterbi_acs_butterfly.sv
// rtl/viterbi_acs_butterfly.sv - one radix-2 butterfly: predecessors 2I, 2I+1 feed states I and I+N_ST/2
module viterbi_acs_butterfly
  import viterbi_pkg::*;
#(
  parameter int K   = K_DEF,
  parameter int G0  = G0_DEF,
  parameter int G1  = G1_DEF,
  parameter int W   = W_DEF,
  parameter int BMW = BMW_DEF,
  parameter int I   = 0
)
(
  input  logic [W-1:0]         pm_p0,
  input  logic [W-1:0]         pm_p1,
  input  logic [4*BMW-1:0]     bm,
  output logic [1:0][W-1:0]    new_pm,
  output logic [1:0]           dec
);
  localparam int N_ST = 1 << (K - 1);
  localparam int P0   = 2 * I;
  localparam logic [W-1:0] MAX = '1;

  // An unreachable predecessor (MAX) must stay unreachable regardless of the branch cost.
  function automatic logic [W-1:0] sat_add(input logic [W-1:0] pm, input logic [BMW-1:0] cost);
    logic [W:0] sum;
    sum = {1'b0, pm} + (W+1)'(cost);
    if (pm == MAX || sum > {1'b0, MAX}) return MAX;
    return sum[W-1:0];
  endfunction

  for (genvar u = 0; u < 2; u++) begin : g_next
    localparam logic [1:0] H0 = expected_bits(u * N_ST + P0, G0, G1);
    localparam logic [1:0] H1 = expected_bits(u * N_ST + P0 + 1, G0, G1);
    logic [W-1:0] cand0;
    logic [W-1:0] cand1;

    assign cand0     = sat_add(pm_p0, bm[H0*BMW +: BMW]);
    assign cand1     = sat_add(pm_p1, bm[H1*BMW +: BMW]);
    assign dec[u]    = cand0 > cand1;
    assign new_pm[u] = dec[u] ? cand1 : cand0;
  end
endmodule

// File: rtl/viterbi_acs_array.sv
// rtl/viterbi_acs_array.sv - full-trellis add-compare-select with renormalisation, best-state search and flow control
module viterbi_acs_array
  import viterbi_pkg::*;
#(
  parameter int K   = K_DEF,
  parameter int G0  = G0_DEF,
  parameter int G1  = G1_DEF,
  parameter int W   = W_DEF,
  parameter int BMW = BMW_DEF
)
(
  input  logic                 clock,
  input  logic                 reset,
  viterbi_acs_array_if.slave   bus
);
  localparam int N_ST   = 1 << (K - 1);
  localparam int HALF_N = N_ST / 2;
  localparam logic [W-1:0] HALF = {1'b1, {(W-1){1'b0}}};

  logic [N_ST-1:0][W-1:0] pm_q, pm_d;
  logic [N_ST-1:0][W-1:0] init_pm, pred, new_pm, stored;
  logic [N_ST-1:0]        dec_q, dec_d, new_dec;
  logic                   dec_valid_q, dec_valid_d;
  logic                   norm_q, norm_d;
  logic [K-2:0]           best_state_q, best_state_d, min_state;
  logic [W-1:0]           best_metric_q, best_metric_d, min_metric;
  logic                   renorm;
  logic                   xfer;

  assign bus.bm_ready = !dec_valid_q || bus.dec_ready;
  assign xfer         = bus.bm_valid && bus.bm_ready;

  always_comb begin
    init_pm = '0;
    for (int j = 0; j < N_ST; j++) init_pm[j] = W'(init_metric(j, W));
  end

  assign pred = bus.start ? init_pm : pm_q;

  for (genvar i = 0; i < HALF_N; i++) begin : g_bfly
    logic [1:0][W-1:0] nm;
    logic [1:0]        db;

    viterbi_acs_butterfly #(.K(K), .G0(G0), .G1(G1), .W(W), .BMW(BMW), .I(i)) u_bfly (
      .pm_p0  (pred[2*i]),
      .pm_p1  (pred[2*i+1]),
      .bm     (bus.bm),
      .new_pm (nm),
      .dec    (db)
    );

    assign new_pm[i]          = nm[0];
    assign new_pm[i+HALF_N]   = nm[1];
    assign new_dec[i]         = db[0];
    assign new_dec[i+HALF_N]  = db[1];
  end

  // Renormalise only when every state has its top bit set, so subtracting HALF never underflows.
  always_comb begin
    renorm = 1'b1;
    for (int j = 0; j < N_ST; j++) if (new_pm[j] < HALF) renorm = 1'b0;
    stored = new_pm;
    if (renorm) for (int j = 0; j < N_ST; j++) stored[j] = new_pm[j] - HALF;
    min_metric = stored[0];
    min_state  = '0;
    for (int j = 1; j < N_ST; j++) begin
      if (stored[j] < min_metric) begin
        min_metric = stored[j];
        min_state  = (K-1)'(j);
      end
    end
  end

  always_comb begin
    pm_d          = pm_q;
    dec_d         = dec_q;
    norm_d        = norm_q;
    best_state_d  = best_state_q;
    best_metric_d = best_metric_q;
    dec_valid_d   = dec_valid_q;
    if (xfer) begin
      pm_d          = stored;
      dec_d         = new_dec;
      norm_d        = renorm;
      best_state_d  = min_state;
      best_metric_d = min_metric;
      dec_valid_d   = 1'b1;
    end else if (bus.dec_ready) begin
      dec_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < N_ST; j++) pm_q[j] <= W'(init_metric(j, W));
      dec_q         <= '0;
      norm_q        <= 1'b0;
      best_state_q  <= '0;
      best_metric_q <= '0;
      dec_valid_q   <= 1'b0;
    end else begin
      pm_q          <= pm_d;
      dec_q         <= dec_d;
      norm_q        <= norm_d;
      best_state_q  <= best_state_d;
      best_metric_q <= best_metric_d;
      dec_valid_q   <= dec_valid_d;
    end
  end

  assign bus.dec_valid   = dec_valid_q;
  assign bus.dec         = dec_q;
  assign bus.norm_pulse  = norm_q;
  assign bus.best_state  = best_state_q;
  assign bus.best_metric = best_metric_q;
endmodule

// File: tb/tb_viterbi_acs_array.sv
// tb/tb_viterbi_acs_array.sv - directed and random checks of the ACS array against a trellis-level model
module tb_viterbi_acs_array;
  localparam int NST   = 4;
  localparam int MAXV  = 15;
  localparam int HALFV = 8;
  localparam int GEN0  = 'o7;
  localparam int GEN1  = 'o5;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  viterbi_acs_array_if #(.K(3), .W(4), .BMW(2)) bus ();

  viterbi_acs_array #(.K(3), .G0('o7), .G1('o5), .W(4), .BMW(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int m_pm [NST];
  int m_dec, m_valid, m_norm, m_bs, m_bm;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int parity(input int v);
    int p = 0;
    for (int i = 0; i < 32; i++) p ^= (v >> i) & 1;
    return p;
  endfunction

  task automatic model_reset();
    for (int j = 0; j < NST; j++) m_pm[j] = (j == 0) ? 0 : MAXV;
    m_dec = 0; m_valid = 0; m_norm = 0; m_bs = 0; m_bm = 0;
  endtask

  task automatic model_symbol(input bit st, input logic [7:0] b);
    int pred [NST];
    int nw [NST];
    int cand [2];
    int allhi;
    for (int p = 0; p < NST; p++) pred[p] = st ? ((p == 0) ? 0 : MAXV) : m_pm[p];
    m_dec = 0;
    for (int j = 0; j < NST; j++) begin
      int u = j / (NST / 2);
      for (int k = 0; k < 2; k++) begin
        int p = (2 * j) % NST + k;
        int r = u * NST + p;
        int h = 2 * parity(r & GEN0) + parity(r & GEN1);
        int cost = (b >> (2 * h)) & 3;
        cand[k] = (pred[p] == MAXV) ? MAXV : ((pred[p] + cost > MAXV) ? MAXV : pred[p] + cost);
      end
      if (cand[0] <= cand[1]) nw[j] = cand[0];
      else begin
        nw[j] = cand[1];
        m_dec |= (1 << j);
      end
    end
    allhi = 1;
    for (int j = 0; j < NST; j++) if (nw[j] < HALFV) allhi = 0;
    for (int j = 0; j < NST; j++) m_pm[j] = allhi ? nw[j] - HALFV : nw[j];
    m_norm = allhi;
    m_bs = 0;
    m_bm = m_pm[0];
    for (int j = 1; j < NST; j++) if (m_pm[j] < m_bm) begin m_bm = m_pm[j]; m_bs = j; end
    m_valid = 1;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_valid"}, bus.dec_valid, m_valid);
    chk({tag, "_dec"}, bus.dec, m_dec);
    chk({tag, "_norm"}, bus.norm_pulse, m_norm);
    chk({tag, "_bstate"}, bus.best_state, m_bs);
    chk({tag, "_bmetric"}, bus.best_metric, m_bm);
  endtask

  // Called at a falling edge; drives one cycle, then checks at the next falling edge.
  task automatic step(input string tag, input bit st, input bit v, input logic [7:0] b,
                      input bit rdy, output bit acc);
    bus.start = st; bus.bm_valid = v; bus.bm = b; bus.dec_ready = rdy;
    #1;
    chk({tag, "_bm_ready"}, bus.bm_ready, (!m_valid || rdy) ? 1 : 0);
    acc = v && (!m_valid || rdy);
    @(posedge clock);
    if (acc) model_symbol(st, b);
    else if (rdy) m_valid = 0;
    @(negedge clock);
    check_outputs(tag);
  endtask

  initial begin
    bit acc;
    bit p_st;
    logic [7:0] p_bm;
    bus.start = 0; bus.bm_valid = 0; bus.bm = '0; bus.dec_ready = 1;
    model_reset();
    repeat (2) @(negedge clock);
    check_outputs("rst_held");
    reset = 1'b0;
    @(negedge clock);
    check_outputs("rst_idle");
    chk("rst_bm_ready", bus.bm_ready, 1);

    // start + rx 00 (bm 00:0 01:1 10:1 11:2)
    step("first", 1, 1, 8'b10_01_01_00, 1, acc);
    chk("first_dec_const", bus.dec, 0);
    chk("first_bmetric_const", bus.best_metric, 0);
    chk("first_norm_const", bus.norm_pulse, 0);

    // all branch costs 1 for eight symbols
    for (int n = 1; n <= 8; n++) begin
      step("ones", n == 1, 1, 8'h55, 1, acc);
      if (n >= 2) chk("ones_metric_const", bus.best_metric, (n == 8) ? 0 : n);
      chk("ones_norm_const", bus.norm_pulse, (n == 8) ? 1 : 0);
    end

    // equal predecessors with equal costs: every select is a tie and must pick upper
    for (int n = 0; n < 4; n++) begin
      step("tie", 0, 1, 8'hFF, 1, acc);
      chk("tie_dec_const", bus.dec, 0);
    end

    // equal minima in states 1 and 3 -> lowest index wins
    step("mintie_a", 1, 1, 8'h00, 1, acc);
    step("mintie_b", 0, 1, 8'b10_01_01_10, 1, acc);
    chk("mintie_state_const", bus.best_state, 1);
    chk("mintie_metric_const", bus.best_metric, 1);

    // downstream stall: nothing accepted, outputs frozen, then resume
    p_st = 0; p_bm = 8'($urandom);
    for (int n = 0; n < 3; n++) begin
      step("stall", p_st, 1, p_bm, 0, acc);
      chk("stall_bm_ready_const", bus.bm_ready, 0);
      if (acc) p_bm = 8'($urandom);
    end
    for (int n = 0; n < 4; n++) begin
      step("resume", p_st, 1, p_bm, 1, acc);
      if (acc) p_bm = 8'($urandom);
    end

    // mid-frame reset
    for (int n = 0; n < 5; n++) step("pre_rst", n == 0, 1, 8'($urandom), 1, acc);
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("midrst_valid_const", bus.dec_valid, 0);
    check_outputs("midrst");
    @(negedge clock);
    reset = 1'b0;
    step("post_rst", 1, 1, 8'b10_01_01_00, 1, acc);
    chk("post_rst_dec_const", bus.dec, 0);
    chk("post_rst_bstate_const", bus.best_state, 0);

    // random traffic with random back-pressure
    p_st = 1; p_bm = 8'($urandom);
    for (int n = 0; n < 400; n++) begin
      step("rand", p_st, $urandom_range(3, 0) != 0, p_bm, $urandom_range(3, 0) != 0, acc);
      if (acc) begin
        p_st = ($urandom_range(15, 0) == 0);
        p_bm = 8'($urandom);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
